// File: rtl/if_fetch_if.sv
// if_fetch_if: ROM fetch bus, execute redirect and decode handshake for the
// instruction-fetch stage. The master modport is the fetch unit; the slave
// modport is the environment (ROM, execute and decode stages).
interface if_fetch_if;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  modport master (
    output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o,
    input  rom_data_i, branch_flag_i, branch_target_i, id_ready_i
  );

  modport slave (
    input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o,
    output rom_data_i, branch_flag_i, branch_target_i, id_ready_i
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: single-cycle instruction fetch into a DEPTH-entry queue feeding
// decode. A redirect flushes the queue and reloads the PC.
// Optional feature: define IF_FETCH_CNT_EN to add fetch_cnt_o, a 32-bit count
// of instructions pushed since reset.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  if_fetch_if.master    bus
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0]   fetch_cnt_o
`endif
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic full, push, pop;

  // Output decode: ROM request, queue head presentation and push/pop strobes.
  always_comb begin
    full           = (count_q == FULL_CNT);
    bus.rom_addr_o = pc_q;
    bus.rom_ce_o   = !rst && !full && !bus.branch_flag_i;
    bus.id_valid_o = (count_q != '0);
    bus.id_pc_o    = 32'h0;
    bus.id_inst_o  = NOP_INST;
    if (bus.id_valid_o) begin
      bus.id_pc_o   = pc_mem_q[rd_ptr_q];
      bus.id_inst_o = inst_mem_q[rd_ptr_q];
    end
    push = bus.rom_ce_o;
    pop  = bus.id_valid_o && bus.id_ready_i && !bus.branch_flag_i;
  end

  // Next-state: redirect wins over push/pop; otherwise advance PC and pointers.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.branch_flag_i) begin
      pc_d     = bus.branch_target_i & ~32'h3;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: PC, pointers and occupancy, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage: write the fetched PC/instruction pair at the tail.
  // NOTE: the storage array has no reset; count_q gates every read, so stale
  // contents are never observable and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      inst_mem_q[wr_ptr_q] <= bus.rom_data_i;
    end
  end

`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  // Push counter: redirects do not clear it, wraps naturally at 2^32.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (push) fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  // Push counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_cnt_q <= 32'h0;
    else     fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_if_fetch;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  if_fetch_if bus0();
  if_fetch_if bus1();

`ifdef IF_FETCH_CNT_EN
  logic [31:0] cnt0, cnt1;
`endif

  if_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
`ifdef IF_FETCH_CNT_EN
    , .fetch_cnt_o (cnt0)
`endif
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
`ifdef IF_FETCH_CNT_EN
    , .fetch_cnt_o (cnt1)
`endif
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus0.rom_data_i = rom_word(bus0.rom_addr_o);
  assign bus1.rom_data_i = rom_word(bus1.rom_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive dut0 inputs at the current negedge and let combinational outputs settle.
  task automatic drive(input logic rdy, input logic br, input logic [31:0] tgt);
    bus0.id_ready_i      = rdy;
    bus0.branch_flag_i   = br;
    bus0.branch_target_i = tgt;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Hold reset for two cycles, check reset outputs, release on a negedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    check("rst_ce",    32'(bus0.rom_ce_o),   32'h0);
    check("rst_valid", 32'(bus0.id_valid_o), 32'h0);
    check("rst_pc",    bus0.id_pc_o,         32'h0);
    check("rst_inst",  bus0.id_inst_o,       32'h13);
    check("rst_addr",  bus0.rom_addr_o,      32'h0);
    check("rst_addr1", bus1.rom_addr_o,      32'hFFFF_FFF8);
`ifdef IF_FETCH_CNT_EN
    check("rst_cnt",   cnt0,                 32'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        ready;
    logic        br;
    logic [31:0] tgt;
    logic        exp_ce;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[17];

  // Reference model state.
  logic [31:0] mq[$];
  logic [31:0] mpc;
  logic [31:0] mcnt;

  initial begin
    logic [31:0] exp_seq[5];
    logic [31:0] exp_inst;
    logic [31:0] head;
    int          pushes;
    int          got;
    logic        rdy, br, e_ce, e_valid;
    logic [31:0] tgt;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus0.id_ready_i      = 1'b0;
    bus0.branch_flag_i   = 1'b0;
    bus0.branch_target_i = 32'h0;
    bus1.id_ready_i      = 1'b1;
    bus1.branch_flag_i   = 1'b0;
    bus1.branch_target_i = 32'h0;

    //               ready br   target        ce    addr          valid head pc
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h4};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h8};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'h8};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h14,       1'b1, 32'h8};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h18,       1'b1, 32'h8};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h18,       1'b1, 32'h8};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h18,       1'b1, 32'h8};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h18,       1'b1, 32'hC};
    vecs[10] = '{1'b1, 1'b1, 32'h103,      1'b0, 32'h1C,       1'b1, 32'hC};
    vecs[11] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h100,      1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h104,      1'b1, 32'h100};
    vecs[13] = '{1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h108,      1'b1, 32'h104};
    vecs[14] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'hFFFFFFFC};
    vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h0};

    // Directed vector table from reset.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].ready, vecs[i].br, vecs[i].tgt);
      exp_inst = vecs[i].exp_valid ? rom_word(vecs[i].exp_pc) : 32'h13;
      check($sformatf("vec%0d_ce", i),    32'(bus0.rom_ce_o),   32'(vecs[i].exp_ce));
      check($sformatf("vec%0d_addr", i),  bus0.rom_addr_o,      vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), 32'(bus0.id_valid_o), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_pc", i),    bus0.id_pc_o,         vecs[i].exp_pc);
      check($sformatf("vec%0d_inst", i),  bus0.id_inst_o,       exp_inst);
      tick();
    end

    // PC wrap from RESET_PC = FFFFFFF8 on the second instance.
    do_reset();
    exp_seq[0] = 32'hFFFF_FFF8;
    exp_seq[1] = 32'hFFFF_FFFC;
    exp_seq[2] = 32'h0000_0000;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 32'h0);
      check($sformatf("wrap%0d_valid", c), 32'(bus1.id_valid_o), (c == 0) ? 32'h0 : 32'h1);
      if (c > 0) begin
        check($sformatf("wrap%0d_pc", c),   bus1.id_pc_o,   exp_seq[c-1]);
        check($sformatf("wrap%0d_inst", c), bus1.id_inst_o, rom_word(exp_seq[c-1]));
      end
      tick();
    end

    // Stall 10 cycles: exactly DEPTH pushes, then drain in order.
    do_reset();
    pushes = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 32'h0);
      if (bus0.rom_ce_o) pushes++;
      tick();
    end
    drive(1'b0, 1'b0, 32'h0);
    check("stall_pushes", 32'(pushes), 32'(DEPTH));
    check("stall_ce",     32'(bus0.rom_ce_o), 32'h0);
    check("stall_pcq",    bus0.rom_addr_o, 32'h10);
    for (int k = 0; k < 5; k++) exp_seq[k] = 32'(k * 4);
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      drive(1'b1, 1'b0, 32'h0);
      if (bus0.id_valid_o) begin
        check($sformatf("drain%0d_pc", got),   bus0.id_pc_o,   exp_seq[got]);
        check($sformatf("drain%0d_inst", got), bus0.id_inst_o, rom_word(exp_seq[got]));
        got++;
      end
      tick();
    end
    check("drain_count", 32'(got), 32'h5);

    // Asynchronous reset with three entries queued.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 32'h0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0);
    check("arst_pre_valid", 32'(bus0.id_valid_o), 32'h1);
    check("arst_pre_ce",    32'(bus0.rom_ce_o),   32'h1);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus0.id_valid_o), 32'h0);
    check("arst_ce",    32'(bus0.rom_ce_o),   32'h0);
    check("arst_pc",    bus0.id_pc_o,         32'h0);
    check("arst_inst",  bus0.id_inst_o,       32'h13);
    check("arst_addr",  bus0.rom_addr_o,      32'h0);
    tick();

    // Randomized run against the queue model.
    do_reset();
    mq.delete();
    mpc  = 32'h0;
    mcnt = 32'h0;
    for (int c = 0; c < 600; c++) begin
      rdy = ($urandom_range(0, 9) < 6);
      br  = ($urandom_range(0, 19) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      drive(rdy, br, tgt);
      e_ce    = (mq.size() < DEPTH) && !br;
      e_valid = (mq.size() != 0);
      head    = e_valid ? mq[0] : 32'h0;
      check("rnd_ce",    32'(bus0.rom_ce_o),   32'(e_ce));
      check("rnd_addr",  bus0.rom_addr_o,      mpc);
      check("rnd_valid", 32'(bus0.id_valid_o), 32'(e_valid));
      check("rnd_pc",    bus0.id_pc_o,         head);
      check("rnd_inst",  bus0.id_inst_o,       e_valid ? rom_word(head) : 32'h13);
`ifdef IF_FETCH_CNT_EN
      check("rnd_cnt",   cnt0,                 mcnt);
`endif
      if (br) begin
        mq.delete();
        mpc = {tgt[31:2], 2'b00};
      end else begin
        if (e_valid && rdy) void'(mq.pop_front());
        if (e_ce) begin
          mq.push_back(mpc);
          mpc  = mpc + 32'd4;
          mcnt = mcnt + 32'd1;
        end
      end
      tick();
    end

`ifdef IF_FETCH_CNT_EN
    // Twenty fetches with one redirect in between.
    do_reset();
    for (int c = 0; c < 21; c++) begin
      drive(1'b1, (c == 10), 32'h200);
      tick();
    end
    drive(1'b1, 1'b0, 32'h0);
    check("cnt20", cnt0, 32'd20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
